// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter: FSM state codes, read-owner tags
// and the halfword address step.
package mem_port_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_D_HI  = 2'd1;
    localparam state_t ST_D_FIN = 2'd2;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IF   = 2'd1,
        TAG_DLO  = 2'd2,
        TAG_DHI  = 2'd3
    } rtag_e;

    localparam int HALF_STEP = 2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// 16-bit synchronous memory port: the arbiter is the master, the memory the slave.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
) ();

    logic [ADDR_W-1:0] addr;
    logic              re;
    logic              we;
    logic [15:0]       wdata;
    logic [15:0]       rdata;

    modport master (output addr, re, we, wdata, input rdata);
    modport slave  (input addr, re, we, wdata, output rdata);

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 16-bit memory port between instruction fetch and a 32-bit load/store
// path, splitting data accesses into low/high halfword beats.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int MAX_D_BURST = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [15:0]       if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_done_o,
    output logic [31:0]       d_rdata_o,
    mem_port_arbiter_if.master mem,
    output logic              stall_fetch_o,
    output logic              stall_pc_o
);

    localparam int BURST_W = $clog2(MAX_D_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_D_BURST);
    localparam logic [ADDR_W-1:0] HALF_INC = ADDR_W'(HALF_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(1);

    state_t              state_q, state_d;
    rtag_e               rtag_q, rtag_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [15:0]         lo_q, lo_d;

    logic [ADDR_W-1:0]   memAddr;
    logic                memRe;
    logic                memWe;
    logic [15:0]         memWdata;
    logic                ifGnt;
    logic                dGnt;
    logic                dDone;
    logic [31:0]         dRdata;
    logic                dataWin;

    // Data wins a free slot unless fetch has already waited out a full burst.
    always_comb begin
        state_d  = state_q;
        rtag_d   = TAG_NONE;
        burst_d  = burst_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        lo_d     = lo_q;
        memAddr  = '0;
        memRe    = 1'b0;
        memWe    = 1'b0;
        memWdata = '0;
        ifGnt    = 1'b0;
        dGnt     = 1'b0;
        dDone    = 1'b0;
        dRdata   = '0;
        dataWin  = d_req_i && !((burst_q == BURST_MAX) && if_req_i);

        if (state_q == ST_D_FIN) begin
            dDone  = 1'b1;
            dRdata = {mem.rdata, lo_q};
        end

        if (state_q == ST_D_HI) begin
            memAddr = addr_q + HALF_INC;
            if (we_q) begin
                memWe    = 1'b1;
                memWdata = wdata_q[31:16];
                dDone    = 1'b1;
                state_d  = ST_IDLE;
            end else begin
                memRe   = 1'b1;
                rtag_d  = TAG_DHI;
                state_d = ST_D_FIN;
                if (rtag_q == TAG_DLO) begin
                    lo_d = mem.rdata;
                end
            end
        end else if (dataWin) begin
            memAddr = d_addr_i & ALIGN_MASK;
            dGnt    = 1'b1;
            addr_d  = d_addr_i & ALIGN_MASK;
            we_d    = d_we_i;
            wdata_d = d_wdata_i;
            state_d = ST_D_HI;
            if (d_we_i) begin
                memWe    = 1'b1;
                memWdata = d_wdata_i[15:0];
            end else begin
                memRe  = 1'b1;
                rtag_d = TAG_DLO;
            end
            if (burst_q != BURST_MAX) begin
                burst_d = burst_q + 1'b1;
            end
        end else if (if_req_i) begin
            memAddr = if_addr_i & ALIGN_MASK;
            memRe   = 1'b1;
            ifGnt   = 1'b1;
            rtag_d  = TAG_IF;
            burst_d = '0;
            state_d = ST_IDLE;
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            rtag_q  <= TAG_NONE;
            burst_q <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            rtag_q  <= rtag_d;
            burst_q <= burst_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
        end
    end

    // Reset silences every strobe and bus so an aborted access leaves no trace.
    assign mem.addr      = rst_i ? '0 : memAddr;
    assign mem.re        = !rst_i && memRe;
    assign mem.we        = !rst_i && memWe;
    assign mem.wdata     = rst_i ? '0 : memWdata;
    assign if_gnt_o      = !rst_i && ifGnt;
    assign if_rvalid_o   = !rst_i && (rtag_q == TAG_IF);
    assign if_rdata_o    = if_rvalid_o ? mem.rdata : '0;
    assign d_gnt_o       = !rst_i && dGnt;
    assign d_done_o      = !rst_i && dDone;
    assign d_rdata_o     = rst_i ? '0 : dRdata;
    assign stall_fetch_o = if_req_i && !if_gnt_o;
    assign stall_pc_o    = !if_gnt_o;

endmodule
